seg_mux_display: RTL and testbench
==================================

// Module: seg_mux_display
// PURPOSE
//  Parametrised, time-multiplexed hex driver for NUM_DIGITS common-anode/cathode 7-segment digits
//  sharing one seg[6:0] bus, plus a free-running blink LED. Sits between switch/logic inputs and
//  board pins; replaces the single-digit combinational decoder. Adds per-digit blanking and blinking,
//  an atomic value load, and anti-ghost guard time.
// PARAMETERS
//  NUM_DIGITS     2           digits on the shared bus (1..8)
//  CLK_HZ         48_000_000  clk frequency (HSOSC)
//  REFRESH_HZ     1000        full-frame rate; dwell per digit = CLK_HZ/(REFRESH_HZ*NUM_DIGITS) cycles
//  GUARD_CYC      16          cycles at start of each dwell with all dig_en inactive
//  BLINK_HZ_X10   24          blink frequency x10 (24 = 2.4 Hz); half period = CLK_HZ*5/BLINK_HZ_X10
//  SEG_ACT_LOW    1           1: seg lines active-low
//  DIG_ACT_LOW    1           1: dig_en lines active-low
// PORTS
//  clk        in   1             system clock
//  reset_n    in   1             synchronous, active-low reset
//  load       in   1             strobe: capture value/blank/blink_en this cycle
//  value      in   4*NUM_DIGITS  hex nibbles, digit i = value[4i+3:4i]
//  blank      in   NUM_DIGITS    1 = digit i always dark
//  blink_en   in   NUM_DIGITS    1 = digit i dark while blink phase = 0
//  seg        out  7             seg[0]=A .. seg[6]=G, polarity per SEG_ACT_LOW
//  dig_en     out  NUM_DIGITS    one-hot digit enable, polarity per DIG_ACT_LOW
//  blink_led  out  1             square wave at BLINK_HZ_X10/10, equals blink phase
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): dwell counter, digit idx, blink counter, phase, shadow and pending regs <= 0;
//    seg = all-off level, dig_en = all-inactive, blink_led = 0. Takes effect on that edge; mid-frame
//    reset abandons the frame with no partial output.
//  - Dwell counter 0..DWELL-1; on wrap idx <= idx+1, idx NUM_DIGITS-1 wraps to 0 (frame boundary).
//  - Output regs (1-cycle latency from counter state): dwell_cnt < GUARD_CYC -> dig_en inactive, seg off;
//    else dig_en[idx] active, seg = hex_to_seg(shadow nibble idx) unless blank[idx] or
//    (blink_en[idx] && !phase), in which case seg off while dig_en[idx] stays active.
//  - Hex map (A..G, active-high): 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011
//    6=1011111 7=1110000 8=1111111 9=1111011 A=1110111 b=0011111 C=1001110 d=0111101 E=1001111
//    F=1000111. Bit order in the table is A first; seg[0]=A.
//  - Load: load=1 captures inputs into a pending reg and sets pending. At the next frame boundary,
//    pending is copied to shadow and cleared, so a frame never mixes old and new digits. Several loads
//    before a boundary: last wins. Load on the boundary cycle itself: the new data is used for that
//    frame. No load ever: shadow stays 0, which displays "0" on every digit.
//  - Blink counter 0..HALF-1; on wrap phase toggles. Independent of load and refresh.
//  - All counters are sized by $clog2 of their terminal count and are unsigned. Elaboration-time checks
//    ($error): DWELL > GUARD_CYC, DWELL >= 2, HALF >= 1, NUM_DIGITS in 1..8.
// STRUCTURE
//  - seg_pkg: SEG_W=7, hex_to_seg() function (active-high A..G table above), SEG_BLANK constant.
//  - Sub-module tick_gen #(DIV): counter with 1-cycle tick at wrap, sync active-low reset.
//    Instantiated twice: dwell ticks and blink half-period ticks. Polarity inversion is applied only
//    at the output regs.
// TESTING (bench params: CLK_HZ=1000, REFRESH_HZ=50, NUM_DIGITS=2, GUARD_CYC=2, BLINK_HZ_X10=50
//          -> DWELL=10, HALF=100; SEG_ACT_LOW=DIG_ACT_LOW=0)
//  1 Reset: hold reset_n=0 for 3 cycles -> seg=0, dig_en=00, blink_led=0. Release -> first 2 cycles
//    have dig_en=00, then dig_en=01 with seg=0111111 (digit "0").
//  2 load with value=8'h3A at cycle 5 of frame -> rest of frame still "00"; from next frame:
//    digit0 seg=1110111 for 8 cycles, guard 2, digit1 seg=1001111.
//  3 Sweep all 16 nibbles on digit0 -> seg matches hex table exactly; dig_en never shows 2 bits set.
//  4 blink_en=01, blank=10 -> digit0 dark for 100 cycles and lit for 100, in phase with blink_led;
//    digit1 seg=0 always while dig_en=10.
//  5 Two loads (8'h11, then 8'h22) in one frame, then a load on the boundary cycle (8'h33) ->
//    next frame shows "33", and never shows "11".
//  6 reset_n=0 mid-dwell of digit1 -> next edge gives dig_en=00 and seg=0; shadow is cleared (shows "00").

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment width, off pattern and hex decoder
package seg_pkg;
   localparam int SEG_W = 7;
   typedef logic [SEG_W-1:0] seg_t;
   localparam seg_t SEG_BLANK = '0;
   // rows read A..G left to right, so bit 6 of each row is segment A
   localparam seg_t HEX_AG [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };
   function automatic seg_t hex_to_seg(input logic [3:0] nib);
      seg_t row;
      seg_t s;
      row = HEX_AG[nib];
      for (int i = 0; i < SEG_W; i++) s[i] = row[SEG_W-1-i];
      return s;
   endfunction
endpackage

// File: rtl/seg_mux_display_tick_gen.sv
// tick_gen: modulo-DIV counter with a one-cycle tick on its last count
module tick_gen #(
   parameter int DIV = 2,
   localparam int W = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic         clk,
   input  logic         reset_n,
   output logic [W-1:0] cnt,
   output logic         tick
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      tick  = cnt_q == W'(DIV - 1);
      cnt_d = tick ? '0 : cnt_q + W'(1);
   end
   always_ff @(posedge clk) begin
      if (!reset_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign cnt = cnt_q;
endmodule

// File: rtl/seg_mux_display.sv
// seg_mux_display: time-multiplexed hex display driver with blanking, blinking and guard time
module seg_mux_display
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 2,
   parameter int CLK_HZ       = 48_000_000,
   parameter int REFRESH_HZ   = 1000,
   parameter int GUARD_CYC    = 16,
   parameter int BLINK_HZ_X10 = 24,
   parameter bit SEG_ACT_LOW  = 1'b1,
   parameter bit DIG_ACT_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [NUM_DIGITS-1:0]   blink_en,
   output logic [SEG_W-1:0]        seg,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic                    blink_led
);
   localparam int DWELL = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
   localparam int HALF  = CLK_HZ * 5 / BLINK_HZ_X10;
   localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int HW    = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int VW    = 4 * NUM_DIGITS;
   localparam logic [DW-1:0] GUARD = DW'(GUARD_CYC);
   localparam seg_t SEG_INV = {SEG_W{SEG_ACT_LOW}};
   localparam logic [NUM_DIGITS-1:0] DIG_INV = {NUM_DIGITS{DIG_ACT_LOW}};

   if (DWELL <= GUARD_CYC) begin : g_chk_guard
      $error("seg_mux_display: DWELL (%0d) must exceed GUARD_CYC (%0d)", DWELL, GUARD_CYC);
   end
   if (DWELL < 2) begin : g_chk_dwell
      $error("seg_mux_display: DWELL (%0d) must be at least 2", DWELL);
   end
   if (HALF < 1) begin : g_chk_half
      $error("seg_mux_display: HALF (%0d) must be at least 1", HALF);
   end
   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_chk_digits
      $error("seg_mux_display: NUM_DIGITS (%0d) must be 1..8", NUM_DIGITS);
   end

   logic [DW-1:0] dwell_cnt;
   logic [HW-1:0] blink_cnt_unused;
   logic          dwell_tick, blink_tick;

   tick_gen #(.DIV(DWELL)) u_dwell (
      .clk     (clk),
      .reset_n (reset_n),
      .cnt     (dwell_cnt),
      .tick    (dwell_tick)
   );

   tick_gen #(.DIV(HALF)) u_blink (
      .clk     (clk),
      .reset_n (reset_n),
      .cnt     (blink_cnt_unused),
      .tick    (blink_tick)
   );

   logic [VW-1:0]         pend_val_q, pend_val_d, sh_val_q, sh_val_d;
   logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d, sh_blank_q, sh_blank_d;
   logic [NUM_DIGITS-1:0] pend_blink_q, pend_blink_d, sh_blink_q, sh_blink_d;
   logic [NUM_DIGITS-1:0] dig_q, dig_d;
   logic                  pend_q, pend_d, phase_q, phase_d;
   logic [IW-1:0]         idx_q, idx_d;
   seg_t                  seg_q, seg_d;
   logic                  frame_end, take, guard, dark;
   logic [3:0]            nib;

   always_comb begin
      frame_end    = dwell_tick && idx_q == IW'(NUM_DIGITS - 1);
      take         = load || pend_q;
      pend_val_d   = load ? value : pend_val_q;
      pend_blank_d = load ? blank : pend_blank_q;
      pend_blink_d = load ? blink_en : pend_blink_q;
      pend_d       = take && !frame_end;
      // a load landing on the boundary cycle goes straight into this frame
      sh_val_d     = (frame_end && take) ? pend_val_d : sh_val_q;
      sh_blank_d   = (frame_end && take) ? pend_blank_d : sh_blank_q;
      sh_blink_d   = (frame_end && take) ? pend_blink_d : sh_blink_q;
      idx_d        = !dwell_tick ? idx_q : frame_end ? '0 : idx_q + IW'(1);
      phase_d      = phase_q ^ blink_tick;
      nib          = sh_val_q[{idx_q, 2'b00} +: 4];
      guard        = dwell_cnt < GUARD;
      dark         = guard || sh_blank_q[idx_q] || (sh_blink_q[idx_q] && !phase_q);
      seg_d        = (dark ? SEG_BLANK : hex_to_seg(nib)) ^ SEG_INV;
      dig_d        = (guard ? '0 : NUM_DIGITS'(1) << idx_q) ^ DIG_INV;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pend_val_q   <= '0;
         pend_blank_q <= '0;
         pend_blink_q <= '0;
         pend_q       <= 1'b0;
         sh_val_q     <= '0;
         sh_blank_q   <= '0;
         sh_blink_q   <= '0;
         idx_q        <= '0;
         phase_q      <= 1'b0;
         seg_q        <= SEG_INV;
         dig_q        <= DIG_INV;
      end else begin
         pend_val_q   <= pend_val_d;
         pend_blank_q <= pend_blank_d;
         pend_blink_q <= pend_blink_d;
         pend_q       <= pend_d;
         sh_val_q     <= sh_val_d;
         sh_blank_q   <= sh_blank_d;
         sh_blink_q   <= sh_blink_d;
         idx_q        <= idx_d;
         phase_q      <= phase_d;
         seg_q        <= seg_d;
         dig_q        <= dig_d;
      end
   end

   assign seg       = seg_q;
   assign dig_en    = dig_q;
   assign blink_led = phase_q;
endmodule

// File: tb/tb_seg_mux_display.sv
// tb_seg_mux_display: directed and random stimulus against a cycle-count reference model
module tb_seg_mux_display;
   localparam int ND    = 2;
   localparam int DWELL = 10;
   localparam int HALF  = 100;
   localparam int GUARD = 2;
   // segment patterns written G..A, i.e. seg[6]..seg[0]
   localparam logic [6:0] HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic          clk = 1'b0, reset_n = 1'b0, load = 1'b0;
   logic [4*ND-1:0] value = '0;
   logic [ND-1:0] blank = '0, blink_en = '0;
   logic [6:0]    seg;
   logic [ND-1:0] dig_en;
   logic          blink_led;

   int n_cmp = 0, n_fail = 0;
   int k = 0;
   bit pv = 1'b0;
   logic [4*ND-1:0] pv_val = '0, sh_val = '0;
   logic [ND-1:0] pv_bl = '0, pv_bk = '0, sh_bl = '0, sh_bk = '0;

   always #5 clk = ~clk;

   seg_mux_display #(
      .NUM_DIGITS   (ND),
      .CLK_HZ       (1000),
      .REFRESH_HZ   (50),
      .GUARD_CYC    (GUARD),
      .BLINK_HZ_X10 (50),
      .SEG_ACT_LOW  (1'b0),
      .DIG_ACT_LOW  (1'b0)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load),
      .value     (value),
      .blank     (blank),
      .blink_en  (blink_en),
      .seg       (seg),
      .dig_en    (dig_en),
      .blink_led (blink_led)
   );

   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%b exp=%b at k=%0d", tag, got, exp, k);
      end
   endtask

   // one clock: predict the outputs from the cycle count since reset, then compare
   task automatic step();
      logic [6:0] es;
      logic [ND-1:0] ed;
      logic el;
      int d, i, ph;
      if (!reset_n) begin
         es = '0; ed = '0; k = 0; pv = 1'b0;
         sh_val = '0; sh_bl = '0; sh_bk = '0;
      end else begin
         d  = k % DWELL;
         i  = (k / DWELL) % ND;
         ph = (k / HALF) % 2;
         ed = (d < GUARD) ? '0 : ND'(1 << i);
         es = (d < GUARD || sh_bl[i] || (sh_bk[i] && ph == 0)) ? 7'h00 : HEX[sh_val[4*i +: 4]];
         if (load) begin
            pv = 1'b1; pv_val = value; pv_bl = blank; pv_bk = blink_en;
         end
         if (k % (DWELL * ND) == DWELL * ND - 1 && pv) begin
            sh_val = pv_val; sh_bl = pv_bl; sh_bk = pv_bk; pv = 1'b0;
         end
         k++;
      end
      el = ((k / HALF) % 2) == 1;
      @(posedge clk);
      #1;
      check("seg", seg, es);
      check("dig_en", 7'(dig_en), 7'(ed));
      check("blink_led", 7'(blink_led), 7'(el));
      check("dig_onehot", 7'($countones(dig_en) <= 1), 7'd1);
   endtask

   task automatic do_load(input logic [4*ND-1:0] v, input logic [ND-1:0] bl, input logic [ND-1:0] bk);
      value = v; blank = bl; blink_en = bk; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      repeat (5) step();
      do_load(8'h3A, 2'b00, 2'b00);
      repeat (40) step();
      for (int n = 0; n < 16; n++) begin
         while (k % (DWELL * ND) != 7) step();
         do_load({4'h0, 4'(n)}, 2'b00, 2'b00);
         repeat (20) step();
      end
      do_load(8'h5C, 2'b10, 2'b01);
      repeat (420) step();
      while (k % (DWELL * ND) != 3) step();
      do_load(8'h11, 2'b00, 2'b00);
      repeat (4) step();
      do_load(8'h22, 2'b00, 2'b00);
      while (k % (DWELL * ND) != DWELL * ND - 1) step();
      do_load(8'h33, 2'b00, 2'b00);
      repeat (40) step();
      while (k % (DWELL * ND) != DWELL + 4) step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      repeat (25) step();
      repeat (1500) begin
         if ($urandom_range(0, 7) == 0) begin
            value = 8'($urandom); blank = 2'($urandom); blink_en = 2'($urandom); load = 1'b1;
         end else load = 1'b0;
         if ($urandom_range(0, 399) == 0) reset_n = 1'b0;
         step();
         reset_n = 1'b1;
      end
      load = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
